// File: rtl/atari_bus_pkg.sv
// Shared types for the CPU/MARIA memory bus arbiter.
package atari_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {IDLE, CPU_A, CPU_D, DMA_A, DMA_D} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} bus_owner_t;

endpackage

// File: rtl/dma_burst_ctr.sv
// Saturating count of consecutive DMA grants; at_max_o lets a waiting CPU in.
module dma_burst_ctr #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [7:0] MaxCnt = 8'(MAX);

  logic [7:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == MaxCnt);

  // Clear wins over increment so a CPU grant always restarts the burst window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter: 6502 CPU vs MARIA DMA, DMA priority with bounded CPU starvation.
module mem_bus_arbiter
  import atari_bus_pkg::*;
#(
  parameter int          ADDR_W        = ADDR_W_DEF,
  parameter int          DATA_W        = DATA_W_DEF,
  parameter int unsigned MAX_DMA_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_e,
  input  logic [DATA_W-1:0] mem_data_out
);

  arb_state_t        state_q;
  logic              cpu_ack_q, dma_ack_q, mem_read_e_q, acc_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q, cpu_rdata_q, dma_rdata_q;

  logic              arb_en, cpu_hit, dma_hit, grant_dma, grant_cpu, burst_at_max;
  bus_owner_t        owner;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // A channel whose ack is still visible is not re-arbitrated that cycle.
  always_comb begin
    arb_en    = (state_q == IDLE) || (state_q == CPU_D) || (state_q == DMA_D);
    cpu_hit   = cpu_req && !cpu_ack_q;
    dma_hit   = dma_req && !dma_ack_q;
    grant_dma = arb_en && dma_hit && !(cpu_hit && burst_at_max);
    grant_cpu = arb_en && !grant_dma && cpu_hit;
    owner     = grant_dma ? OWN_DMA : OWN_CPU;
    sel_addr  = (owner == OWN_DMA) ? dma_addr  : cpu_addr;
    sel_wdata = (owner == OWN_DMA) ? dma_wdata : cpu_wdata;
    sel_we    = (owner == OWN_DMA) ? dma_we    : cpu_we;
  end

  dma_burst_ctr #(
    .MAX (MAX_DMA_BURST)
  ) u_burst (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr_i    (!cpu_req || grant_cpu),
    .inc_i    (grant_dma),
    .at_max_o (burst_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      cpu_ack_q     <= 1'b0;
      dma_ack_q     <= 1'b0;
      mem_read_e_q  <= 1'b1;
      acc_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
    end else begin
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      mem_read_e_q <= 1'b1;
      case (state_q)
        CPU_A: state_q <= CPU_D;
        DMA_A: state_q <= DMA_D;
        CPU_D: begin
          cpu_ack_q <= 1'b1;
          if (!acc_we_q) cpu_rdata_q <= mem_data_out;
        end
        DMA_D: begin
          dma_ack_q <= 1'b1;
          if (!acc_we_q) dma_rdata_q <= mem_data_out;
        end
        default: state_q <= state_q;
      endcase
      if (arb_en) begin
        if (grant_dma || grant_cpu) begin
          state_q       <= grant_dma ? DMA_A : CPU_A;
          mem_addr_q    <= sel_addr;
          mem_data_in_q <= sel_wdata;
          mem_read_e_q  <= !sel_we;
          acc_we_q      <= sel_we;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign dma_ack     = dma_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_read_e  = mem_read_e_q;
  assign cpu_rdy     = !((state_q == DMA_A) || (state_q == DMA_D) || dma_req);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model, synchronous RAM, directed scenarios.
module tb_mem_bus_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cpu_req, cpu_we, cpu_ack, cpu_rdy;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        mem_read_e;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W        (16),
    .DATA_W        (8),
    .MAX_DMA_BURST (MAXB)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .cpu_rdy      (cpu_rdy),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_ack      (dma_ack),
    .dma_rdata    (dma_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_read_e   (mem_read_e),
    .mem_data_out (mem_data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM seen by the arbiter: 1-cycle read latency, writes while read_e low.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin : ram_proc
    logic [7:0] rd;
    rd = ram[mem_addr];
    if (!mem_read_e) ram[mem_addr] = mem_data_in;
    mem_data_out <= rd;
  end

  // Transaction model: at most one access in flight, each taking an address
  // cycle then a data cycle, with the ack appearing the cycle after.
  logic [7:0]  mmem [0:65535];
  bit          m_busy, m_phase, m_owner_dma, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  int          m_burst;
  logic [15:0] e_addr;
  logic [7:0]  e_din, e_crd, e_drd;
  bit          e_re, e_cack, e_dack;

  always @(posedge clk) begin : model
    bit pc, pd, cr, dr;
    if (m_busy && !m_phase && m_we) mmem[m_addr] = m_wdata;
    if (!rst_b) begin
      m_busy = 0; m_phase = 0; m_burst = 0;
      e_addr = '0; e_din = '0; e_crd = '0; e_drd = '0;
      e_re = 1; e_cack = 0; e_dack = 0;
    end else begin
      pc = e_cack; pd = e_dack;
      e_cack = 0; e_dack = 0; e_re = 1;
      if (m_busy && m_phase) begin
        if (m_owner_dma) begin
          e_dack = 1;
          if (!m_we) e_drd = mmem[m_addr];
        end else begin
          e_cack = 1;
          if (!m_we) e_crd = mmem[m_addr];
        end
        m_busy = 0;
      end else if (m_busy) begin
        m_phase = 1;
      end
      if (!m_busy) begin
        cr = cpu_req && !pc;
        dr = dma_req && !pd;
        if (dr && !(cr && m_burst == MAXB)) begin
          m_busy = 1; m_phase = 0; m_owner_dma = 1;
          m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
          if (m_burst < MAXB) m_burst++;
        end else if (cr) begin
          m_busy = 1; m_phase = 0; m_owner_dma = 0;
          m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
          m_burst = 0;
        end
        if (m_busy) begin
          e_addr = m_addr; e_din = m_wdata; e_re = !m_we;
        end
      end
      if (!cpu_req) m_burst = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_addr",    32'(mem_addr),    32'(e_addr));
      check("mem_data_in", 32'(mem_data_in), 32'(e_din));
      check("mem_read_e",  32'(mem_read_e),  32'(e_re));
      check("cpu_ack",     32'(cpu_ack),     32'(e_cack));
      check("dma_ack",     32'(dma_ack),     32'(e_dack));
      check("cpu_rdata",   32'(cpu_rdata),   32'(e_crd));
      check("dma_rdata",   32'(dma_rdata),   32'(e_drd));
      check("cpu_rdy",     32'(cpu_rdy),     32'(!(m_busy && m_owner_dma) && !dma_req));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    ram[a]  = d;
    mmem[a] = d;
  endtask

  task automatic cpu_set(input bit req, input bit we, input logic [15:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_set(input bit req, input bit we, input logic [15:0] a, input logic [7:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  int ack_cyc[$];
  bit ack_cpu[$];
  int cnt;

  initial begin
    rst_b = 1'b0;
    cpu_set(0, 0, '0, '0);
    dma_set(0, 0, '0, '0);
    preload(16'h1234, 8'hA5);
    preload(16'h0100, 8'hC3);
    preload(16'h0200, 8'h5A);
    preload(16'h0300, 8'h11);
    preload(16'h0400, 8'h22);
    tick(); tick();
    chk_en = 1'b1;
    check("rst_mem_read_e", 32'(mem_read_e), 32'd1);
    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    check("rst_cpu_ack",    32'(cpu_ack),    32'd0);
    check("rst_cpu_rdy",    32'(cpu_rdy),    32'd1);
    rst_b = 1'b1;
    tick();

    // CPU read of 1234
    cpu_set(1, 0, 16'h1234, 8'h00);
    tick(); cpu_req = 0;
    check("t1_addr", 32'(mem_addr), 32'h1234);
    tick(); tick();
    check("t1_ack",   32'(cpu_ack),   32'd1);
    check("t1_rdata", 32'(cpu_rdata), 32'hA5);
    tick();
    check("t1_ack_pulse", 32'(cpu_ack), 32'd0);

    // CPU write 0040 <- 3C, then read back
    cpu_set(1, 1, 16'h0040, 8'h3C);
    cnt = 0;
    tick(); cpu_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (!mem_read_e) cnt++;
      if (i == 2) begin
        check("t2_wr_ack",   32'(cpu_ack),   32'd1);
        check("t2_wr_rdata", 32'(cpu_rdata), 32'hA5);
      end
      tick();
    end
    check("t2_we_cycles", 32'(cnt), 32'd1);
    cpu_set(1, 0, 16'h0040, 8'h00);
    tick(); cpu_req = 0;
    tick(); tick();
    check("t2_readback", 32'(cpu_rdata), 32'h3C);
    tick();

    // Collision: DMA wins, CPU follows
    cpu_set(1, 0, 16'h0100, 8'h00);
    dma_set(1, 0, 16'h0200, 8'h00);
    #1 check("t3_rdy_pending", 32'(cpu_rdy), 32'd0);
    tick(); dma_req = 0;
    check("t3_dma_addr", 32'(mem_addr), 32'h0200);
    check("t3_rdy_dma",  32'(cpu_rdy),  32'd0);
    tick(); tick();
    check("t3_dma_ack",   32'(dma_ack),   32'd1);
    check("t3_dma_rdata", 32'(dma_rdata), 32'h5A);
    check("t3_cpu_addr",  32'(mem_addr),  32'h0100);
    check("t3_rdy_back",  32'(cpu_rdy),   32'd1);
    cpu_req = 0;
    tick(); tick();
    check("t3_cpu_ack",   32'(cpu_ack),   32'd1);
    check("t3_cpu_rdata", 32'(cpu_rdata), 32'hC3);
    tick(); tick();

    // Starvation bound: both held
    dma_set(1, 0, 16'h0300, 8'h00);
    cpu_set(1, 0, 16'h0400, 8'h00);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (dma_ack || cpu_ack) begin
        ack_cyc.push_back(c);
        ack_cpu.push_back(cpu_ack);
      end
    end
    dma_req = 0; cpu_req = 0;
    check("t4_ack_count", 32'(ack_cyc.size() >= 18), 32'd1);
    if (ack_cyc.size() >= 18) begin
      check("t4_first_ack", 32'(ack_cyc[0]), 32'd3);
      for (int k = 0; k < 18; k++) begin
        check("t4_owner", 32'(ack_cpu[k]), 32'((k % 9) == 8));
        if (k > 0) check("t4_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd2);
      end
    end
    repeat (5) tick();

    // Reset during a DMA write's address cycle
    dma_set(1, 1, 16'h0500, 8'h77);
    tick(); dma_req = 0;
    check("t5_we_low", 32'(mem_read_e), 32'd0);
    rst_b = 0;
    tick(); rst_b = 1;
    check("t5_re_after", 32'(mem_read_e), 32'd1);
    check("t5_addr_rst", 32'(mem_addr),   32'h0);
    check("t5_rdy",      32'(cpu_rdy),    32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (dma_ack) cnt++;
      tick();
    end
    check("t5_no_ack", 32'(cnt), 32'd0);

    // One-cycle CPU request still completes with a single ack
    cpu_set(1, 0, 16'h1234, 8'h00);
    cnt = 0;
    tick(); cpu_req = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_ack) cnt++;
      tick();
    end
    check("t6_single_ack", 32'(cnt), 32'd1);

    // DMA write then read back
    dma_set(1, 1, 16'h0600, 8'h99);
    tick(); dma_req = 0;
    repeat (3) tick();
    dma_set(1, 0, 16'h0600, 8'h00);
    tick(); dma_req = 0;
    tick(); tick();
    check("t7_dma_readback", 32'(dma_rdata), 32'h99);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
